// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single shared memory port.
// Data requests win by default; a bounded starve counter guarantees fetch progress.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic        error
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] starve_reg, starve_next;
    logic             error_reg, error_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic [3:0]       rmask_reg, rmask_next;
    logic [3:0]       wmask_reg, wmask_next;

    logic i_pend, d_pend, grant_i, grant_d, busy;

    assign i_pend  = |imem_rmask;
    assign d_pend  = |(dmem_rmask | dmem_wmask);
    assign grant_i = i_pend && (!d_pend || (starve_reg == LIMIT));
    assign grant_d = d_pend && !grant_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            starve_reg <= '0;
            error_reg  <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            rmask_reg  <= '0;
            wmask_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            starve_reg <= starve_next;
            error_reg  <= error_next;
            addr_reg   <= addr_next;
            wdata_reg  <= wdata_next;
            rmask_reg  <= rmask_next;
            wmask_reg  <= wmask_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        starve_next = starve_reg;
        error_next  = error_reg;
        addr_next   = addr_reg;
        wdata_next  = wdata_reg;
        rmask_next  = rmask_reg;
        wmask_next  = wmask_reg;
        case (state_reg)
            IDLE: begin
                // A response with nothing outstanding is a memory-side protocol fault.
                if (mem_resp) error_next = 1'b1;
                if (grant_i) begin
                    state_next  = I_BUSY;
                    addr_next   = imem_addr;
                    rmask_next  = imem_rmask;
                    wmask_next  = '0;
                    wdata_next  = '0;
                    starve_next = '0;
                end else if (grant_d) begin
                    state_next = D_BUSY;
                    addr_next  = dmem_addr;
                    rmask_next = dmem_rmask;
                    wmask_next = dmem_wmask;
                    wdata_next = dmem_wdata;
                    if (!i_pend)
                        starve_next = '0;
                    else if (starve_reg != LIMIT)
                        starve_next = starve_reg + 1'b1;
                    if ((|dmem_rmask) && (|dmem_wmask)) error_next = 1'b1;
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy       = (state_reg != IDLE);
    assign mem_addr   = busy ? addr_reg  : 32'h0;
    assign mem_wdata  = busy ? wdata_reg : 32'h0;
    assign mem_rmask  = busy ? rmask_reg : 4'h0;
    assign mem_wmask  = busy ? wmask_reg : 4'h0;

    assign imem_resp  = mem_resp && (state_reg == I_BUSY);
    assign dmem_resp  = mem_resp && (state_reg == D_BUSY);
    assign imem_rdata = imem_resp ? mem_rdata : 32'h0;
    assign dmem_rdata = dmem_resp ? mem_rdata : 32'h0;
    assign error      = error_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL have port imem_addr  input  32  instruction fetch address.
REQ-005 SHALL have port imem_rmask  input  4  fetch byte read mask; nonzero = request pending.
REQ-006 SHALL have port imem_rdata  output  32  fetch read data.
REQ-007 SHALL have port imem_resp  output  1  fetch completion strobe.
REQ-008 SHALL have port dmem_addr  input  32  data access address.
REQ-009 SHALL have port dmem_rmask  input  4  data byte read mask.
REQ-010 SHALL have port dmem_wmask  input  4  data byte write mask; request pending when rmask|wmask nonzero.
REQ-011 SHALL have port dmem_wdata  input  32  store data.
REQ-012 SHALL have port dmem_rdata  output  32  load read data.
REQ-013 SHALL have port dmem_resp  output  1  data completion strobe.
REQ-014 SHALL have ports mem_addr/mem_wdata  output  32 each  shared memory address/store data.
REQ-015 SHALL have ports mem_rmask/mem_wmask  output  4 each  shared memory byte masks.
REQ-016 SHALL have ports mem_rdata  input  32 and mem_resp  input  1  shared memory return.
REQ-017 SHALL have port error  output  1  sticky protocol-violation flag.

Function
REQ-018 SHALL implement FSM states IDLE, I_BUSY, D_BUSY.
REQ-019 In IDLE, SHALL drive mem_rmask=mem_wmask=0, mem_addr=mem_wdata=0.
REQ-020 In IDLE with any request pending, SHALL grant one requester and enter the matching BUSY state on the next edge.
REQ-021 Priority: data over instruction, unless starve counter == STARVE_LIMIT and an instruction request is pending, in which case instruction wins.
REQ-022 Starve counter (width $clog2(STARVE_LIMIT+1)): +1 on data grant with instruction pending; cleared on instruction grant or on data grant with no instruction pending; saturates at STARVE_LIMIT.
REQ-023 On grant SHALL register addr, masks and wdata (imem grant: wmask=0, wdata=0); mem_* outputs in BUSY come only from these registers, immune to requester changes.
REQ-024 Latency: request seen in IDLE cycle N -> mem masks asserted from cycle N+1 until the cycle mem_resp=1 inclusive.
REQ-025 imem_resp = mem_resp & (state==I_BUSY); dmem_resp = mem_resp & (state==D_BUSY); combinational, same cycle as mem_resp.
REQ-026 imem_rdata and dmem_rdata SHALL both equal mem_rdata when their resp is 1, else 0.
REQ-027 BUSY state with mem_resp=1 SHALL return to IDLE on next edge (one mandatory bubble between transactions); with mem_resp=0, remain.
REQ-028 error SHALL set when: dmem_rmask and dmem_wmask both nonzero at a data grant (grant proceeds with both masks forwarded), or mem_resp=1 in IDLE (ignored, no resp forwarded).
REQ-029 error SHALL remain 1 until reset.

Reset
REQ-030 While rst=0, SHALL force state IDLE, starve counter 0, error 0, all registered request fields 0, all outputs 0, asynchronously.
REQ-031 Reset asserted mid-transaction SHALL abort it: mem masks drop immediately, no resp strobe issued afterward; first cycle after release is IDLE.

Verification
REQ-032 Single fetch: imem_rmask=4'hF addr 0x1000 in IDLE -> mem_addr=0x1000, mem_rmask=4'hF next cycle; mem_resp with rdata 0xDEADBEEF 3 cycles later -> imem_resp=1, imem_rdata=0xDEADBEEF same cycle, IDLE next.
REQ-033 Simultaneous: imem and dmem (wmask=4'h3, addr 0x2000) both requesting in IDLE -> D_BUSY first, mem_wmask=4'h3; after its resp + bubble, I_BUSY.
REQ-034 Starvation, STARVE_LIMIT=4: imem and dmem held pending continuously -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-035 Protocol errors: mem_resp=1 in IDLE -> error=1, no resp; dmem_rmask=4'hF with dmem_wmask=4'h1 -> error=1, held until reset.
REQ-036 Reset mid-D_BUSY: rst=0 for 1 cycle -> mem_wmask=0 in same cycle, dmem_resp stays 0, later mem_resp ignored with error set, state IDLE.
